// File: rtl/bt656cap_dma.sv
// Capture-side DMA: packs 16 RGB565 pixels into one 4x64-bit FML write burst and
// walks the frame buffer burst by burst, driving frame/burst bookkeeping for the control block.
//
// Handshakes: a pixel moves on any cycle with v_stb & v_ack; v_ack is high only in FILL.
// A burst is offered with fml_stb and fml_adr held steady until fml_ack; the four data
// words follow on the next four cycles with no further handshake.
module bt656cap_dma #(
    parameter int fml_depth = 27
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,

    input  logic                 v_stb,
    output logic                 v_ack,
    input  logic                 v_sof,
    input  logic                 v_field,
    input  logic [15:0]          v_rgb565,

    input  logic [1:0]           field_filter,
    input  logic [fml_depth-6:0] fml_adr_base,
    input  logic                 last_burst,
    output logic                 in_frame,
    output logic                 start_of_frame,
    output logic                 next_burst,

    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do,

    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_REQ   = 3'd1,
        S_D0    = 3'd2,
        S_D1    = 3'd3,
        S_D2    = 3'd4,
        S_D3    = 3'd5,
        S_NEXT  = 3'd6,
        S_CHECK = 3'd7
    } state_t;

    localparam logic [fml_depth-6:0] ADR_STEP = 1;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cnt;
    logic                 field_q;
    logic [fml_depth-6:0] adr_hi;
    logic [15:0]          pix [16];
    logic                 sof_take;
    logic                 px_store;
    logic [1:0]           word_sel;
    logic [63:0]          word_cur;

    // An enabled v_sof always wins, even mid-field, so a restart discards the partial burst.
    always_comb begin
        sof_take = (state == S_FILL) && v_stb && v_sof && field_filter[v_field];
        px_store = (state == S_FILL) && v_stb && !sof_take && in_frame && (v_field == field_q);
    end

    always_comb begin
        state_nxt  = state;
        v_ack      = 1'b0;
        fml_stb    = 1'b0;
        next_burst = 1'b0;
        case (state)
            S_FILL: begin
                v_ack = 1'b1;
                if (px_store && (cnt == 4'd15))
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                fml_stb = 1'b1;
                if (fml_ack)
                    state_nxt = S_D0;
            end
            S_D0:    state_nxt = S_D1;
            S_D1:    state_nxt = S_D2;
            S_D2:    state_nxt = S_D3;
            S_D3:    state_nxt = S_NEXT;
            S_NEXT: begin
                next_burst = 1'b1;
                state_nxt  = S_CHECK;
            end
            S_CHECK: state_nxt = S_FILL;
            default: state_nxt = S_FILL;
        endcase
    end

    // Word w holds pixels 4w..4w+3, earliest pixel in the most significant lane.
    always_comb begin
        word_sel = 2'd0;
        case (state)
            S_D1:    word_sel = 2'd1;
            S_D2:    word_sel = 2'd2;
            S_D3:    word_sel = 2'd3;
            default: word_sel = 2'd0;
        endcase
        word_cur = {pix[{word_sel, 2'd0}], pix[{word_sel, 2'd1}],
                    pix[{word_sel, 2'd2}], pix[{word_sel, 2'd3}]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= S_FILL;
            cnt            <= 4'd0;
            in_frame       <= 1'b0;
            start_of_frame <= 1'b0;
            field_q        <= 1'b0;
            adr_hi         <= '0;
        end else begin
            state          <= state_nxt;
            start_of_frame <= sof_take;
            if (sof_take) begin
                in_frame <= 1'b1;
                field_q  <= v_field;
                adr_hi   <= fml_adr_base;
                cnt      <= 4'd1;
            end else if (px_store) begin
                cnt <= cnt + 4'd1;
            end
            if (state == S_NEXT)
                adr_hi <= adr_hi + ADR_STEP;
            if ((state == S_CHECK) && last_burst)
                in_frame <= 1'b0;
        end
    end

    // Pixel storage is pure datapath; its contents are only observed after 16 fresh writes.
    always_ff @(posedge sys_clk) begin
        if (sof_take)
            pix[0] <= v_rgb565;
        else if (px_store)
            pix[cnt] <= v_rgb565;
    end

    always_comb begin
        fml_adr   = {adr_hi, 5'd0};
        fml_we    = 1'b1;
        fml_sel   = 8'hff;
        fml_do    = ((state == S_D0) || (state == S_D1) || (state == S_D2) || (state == S_D3))
                    ? word_cur : 64'd0;
        state_dbg = state;
    end

endmodule
